// File: rtl/pulse_rate_limiter.sv
// pulse_rate_limiter
//
// Spaces out a bursty stream of single-cycle event requests so that the
// downstream pulse CDC synchronizer never sees two out_pulse assertions closer
// than GAP clk cycles. Events that arrive while the limiter is holding off are
// queued in a saturating pending counter. Events that arrive while that counter
// is full are dropped, and the sticky ovf flag records the loss.
//
// Parameters
//   GAP    minimum spacing in clk cycles between out_pulse assertions (2..255)
//   CNT_W  width of the pending-event counter (2..8)
//
// Ports
//   clk        input   single clock, rising edge
//   rst        input   synchronous, active-high reset
//   in_pulse   input   event request, one event per high cycle
//   ovf_clr    input   clears the sticky ovf flag (and drop_cnt when present)
//   out_pulse  output  registered one-cycle event pulse
//   pending    output  accepted events not yet emitted (registered)
//   busy       output  pending != 0 or the limiter is in its hold-off window
//   ovf        output  sticky: at least one event was dropped
//   drop_cnt   output  16-bit saturating drop counter, present only when
//                      PULSE_RATE_LIMITER_DROP_CNT_EN is defined
//
// Optional feature macro: PULSE_RATE_LIMITER_DROP_CNT_EN

module pulse_rate_limiter #(
  parameter int GAP   = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pulse,
  input  logic             ovf_clr,
  output logic             out_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             ovf
`ifdef PULSE_RATE_LIMITER_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX   = '1;
  localparam logic [CNT_W-1:0] PEND_ONE   = CNT_W'(1);
  localparam logic [7:0]       GAP_RELOAD = 8'(GAP - 1);

  state_t     state;
  logic [7:0] gap_cnt;

  logic emit;
  logic drop;
  logic accept;

  // Pending update. The decrement only happens on an emit, and with an empty
  // backlog an emit requires in_pulse, so the increment always accompanies it:
  // the counter cannot underflow. The increment is suppressed on a drop, so it
  // cannot wrap either.
  function automatic logic [CNT_W-1:0] pending_next(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec) nxt = cur + PEND_ONE;
    if (dec && !inc) nxt = cur - PEND_ONE;
    return nxt;
  endfunction

`ifdef PULSE_RATE_LIMITER_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] cur);
    return (cur == 16'hFFFF) ? cur : cur + 16'd1;
  endfunction
`endif

  // An arriving event can be emitted in the same edge it is sampled, so with an
  // empty backlog in IDLE it passes straight through without touching pending.
  always_comb begin
    emit   = (state == IDLE) && ((pending != '0) || in_pulse);
    drop   = in_pulse && (pending == PEND_MAX) && !emit;
    accept = in_pulse && !drop;
  end

  assign busy = (pending != '0) || (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= 8'd0;
      pending   <= '0;
      out_pulse <= 1'b0;
      ovf       <= 1'b0;
`ifdef PULSE_RATE_LIMITER_DROP_CNT_EN
      drop_cnt  <= 16'd0;
`endif
    end else begin
      out_pulse <= emit;
      pending   <= pending_next(pending, accept, emit);

      // The hold-off window spans GAP-1 cycles after an emit; the next emit can
      // then happen on the following edge, giving exactly GAP cycles between
      // pulses under continuous backlog.
      if (state == IDLE) begin
        if (emit) begin
          state   <= HOLD;
          gap_cnt <= GAP_RELOAD;
        end
      end else begin
        if (gap_cnt == 8'd1) begin
          state   <= IDLE;
          gap_cnt <= 8'd0;
        end else begin
          gap_cnt <= gap_cnt - 8'd1;
        end
      end

      // A drop coinciding with a clear must not be lost.
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end

`ifdef PULSE_RATE_LIMITER_DROP_CNT_EN
      if (drop) begin
        drop_cnt <= ovf_clr ? 16'd1 : sat_inc16(drop_cnt);
      end else if (ovf_clr) begin
        drop_cnt <= 16'd0;
      end
`endif
    end
  end

endmodule

// File: doc/pulse_rate_limiter.md
PULSE_RATE_LIMITER -- requirements
Module: pulse_rate_limiter

Interface
REQ-001 Parameter GAP, default 4, minimum spacing in clk cycles between out_pulse assertions; legal range 2..255.
REQ-002 Parameter CNT_W, default 4, width of the pending-event counter; legal range 2..8.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_pulse  input  1  event request; each cycle high is one event.
REQ-006 ovf_clr  input  1  clears the sticky ovf flag.
REQ-007 out_pulse  output  1  registered 1-clk event pulse; feeds the src_pulse input of the downstream pulse CDC synchronizer.
REQ-008 pending  output  CNT_W  number of accepted events not yet emitted; registered.
REQ-009 busy  output  1  high when pending != 0 or state == HOLD; combinational from registers.
REQ-010 ovf  output  1  sticky flag: at least one event dropped.

Function
REQ-011 States: IDLE, HOLD.
REQ-012 Emit condition: state == IDLE and (pending != 0 or in_pulse == 1).
REQ-013 On emit: out_pulse <= 1 for exactly one cycle; gap_cnt <= GAP-1; state <= HOLD.
REQ-014 Latency: in_pulse at edge N with empty backlog in IDLE -> out_pulse high in cycle N+1.
REQ-015 In HOLD: gap_cnt decrements each cycle; at the edge where gap_cnt == 1, state <= IDLE and gap_cnt <= 0.
REQ-016 Under continuous backlog, consecutive out_pulse rising edges are exactly GAP cycles apart; never fewer.
REQ-017 pending next = pending + accepted_in - emit, where accepted_in = in_pulse and not dropped; a simultaneous in_pulse and emit leaves pending unchanged.
REQ-018 In IDLE with pending == 0, an in_pulse is emitted directly and never counted into pending.
REQ-019 Drop: in_pulse with pending == 2^CNT_W-1 and no emit that cycle -> event discarded, pending unchanged, ovf <= 1.
REQ-020 pending never wraps past 2^CNT_W-1 and never underflows below 0.
REQ-021 ovf clears on ovf_clr; a drop in the same cycle as ovf_clr wins (ovf stays 1).
REQ-022 out_pulse is never high in two consecutive cycles.

Reset
REQ-023 While rst is high at an edge: state <= IDLE, gap_cnt <= 0, pending <= 0, out_pulse <= 0, ovf <= 0; in_pulse that cycle is discarded.
REQ-024 Reset mid-HOLD or with a backlog discards all pending events; the first post-reset emit follows REQ-014 with no residual gap.

Configuration
REQ-025 Macro PULSE_RATE_LIMITER_DROP_CNT_EN: when defined, adds output drop_cnt (16 bits), reset to 0, incremented on each dropped event, saturating at 0xFFFF.
REQ-026 With the macro defined, ovf_clr also clears drop_cnt; a drop in the same cycle as ovf_clr leaves drop_cnt = 1.
REQ-027 Without the macro, the drop_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-028 GAP=4: single in_pulse at cycle 10 -> out_pulse only at cycle 11; busy high cycles 11..13; pending stays 0.
REQ-029 GAP=4: in_pulse high cycles 10,11,12 -> out_pulse at cycles 11,15,19; pending 0,1,2,1,0 profile, 0 after cycle 18.
REQ-030 CNT_W=2, GAP=4: in_pulse held high 12 cycles -> pending saturates at 3, ovf set at first drop, later emits continue spaced 4 apart until pending = 0.
REQ-031 ovf set, then ovf_clr and a drop in the same cycle -> ovf remains 1; ovf_clr alone next cycle -> ovf = 0 (drop_cnt = 0 with macro).
REQ-032 rst asserted during HOLD with pending = 2 -> all outputs 0 next cycle; in_pulse two cycles after rst release -> out_pulse one cycle later.
REQ-033 Macro defined: force 70000 drops -> drop_cnt saturates at 0xFFFF; macro undefined -> compile succeeds with no drop_cnt port.
